// File: rtl/spi_cmd_pkg.sv
// Shared types and constants for the SPI command bridge.
//   op_e    : command opcode carried in cmd[7:6]
//   state_e : bridge FSM states
//   CMD_*   : bit positions inside the command byte
package spi_cmd_pkg;

   typedef enum logic [1:0] {
      OP_WRITE    = 2'b00,
      OP_READ     = 2'b01,
      OP_SET_ADDR = 2'b10,
      OP_CONTINUE = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_CMD,
      ST_ADDR,
      ST_LEN,
      ST_WR_DATA,
      ST_BUS,
      ST_RD_HOLD,
      ST_DONE
   } state_e;

   localparam int CMD_OP_MSB  = 7;
   localparam int CMD_OP_LSB  = 6;
   localparam int CMD_INC_BIT = 5;
   localparam int CMD_DIR_BIT = 4;
   localparam int CNT_W       = 9;

endpackage

// File: rtl/spi_cmd_addr_ctr.sv
// Bus address register for the SPI command bridge.
//   sys_clk, reset_n : clock, async active-low reset
//   shift_i, byte_i  : shift one address byte in at the LSB end (MSB-first load)
//   inc_i            : increment by one, wrapping modulo 2^ADDR_WIDTH
//   addr_o           : current address
module spi_cmd_addr_ctr #(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  shift_i,
   input  logic [7:0]            byte_i,
   input  logic                  inc_i,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic [ADDR_WIDTH-1:0] addr_q, addr_d, shifted;

   // Bits pushed past the top fall off, so after ADDR_BYTES shifts the
   // excess high bits of the first byte are gone.
   if (ADDR_WIDTH > 8) begin : g_wide
      assign shifted = {addr_q[ADDR_WIDTH-9:0], byte_i};
   end else begin : g_narrow
      assign shifted = byte_i[ADDR_WIDTH-1:0];
   end

   always_comb begin
      addr_d = addr_q;
      if (shift_i)
         addr_d = shifted;
      else if (inc_i)
         addr_d = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) addr_q <= '0;
      else          addr_q <= addr_d;
   end

   assign addr_o = addr_q;

endmodule

// File: rtl/spi_cmd_bridge.sv
// SPI command bridge: turns framed command bytes from the SPI receiver into
// bus read/write bursts and returns read data to the SPI transmitter.
//   sys_clk, reset_n         : clock, async active-low reset
//   frame_active             : chip select (synchronous); low aborts the frame
//   rx_byte, rx_valid        : received byte and its one-cycle strobe
//   tx_byte, tx_load         : byte for the next SPI transfer and its update strobe
//   bus_addr/wr_data/we/req  : bus request side; bus_ack/bus_rd_data response
//   busy                     : FSM not in CMD
//   overrun                  : sticky dropped-byte flag, cleared on frame start
//
// state      | meaning
// -----------+----------------------------------------------------
// ST_CMD     | idle, decode next command byte
// ST_ADDR    | shifting in address bytes
// ST_LEN     | waiting for the transfer count
// ST_WR_DATA | waiting for a write data byte
// ST_BUS     | bus request outstanding
// ST_RD_HOLD | read data presented, waiting for the host dummy byte
// ST_DONE    | burst complete, ignore bytes until the frame ends
module spi_cmd_bridge
   import spi_cmd_pkg::*;
#(
   parameter int ADDR_WIDTH = 17
) (
   input  logic                  sys_clk,
   input  logic                  reset_n,
   input  logic                  frame_active,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   output logic [7:0]            tx_byte,
   output logic                  tx_load,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [7:0]            bus_wr_data,
   output logic                  bus_we,
   output logic                  bus_req,
   input  logic                  bus_ack,
   input  logic [7:0]            bus_rd_data,
   output logic                  busy,
   output logic                  overrun
);

   localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
   localparam int BC_W = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(ADDR_BYTES - 1);

   state_e            state_q, state_d;
   op_e               op_q, op_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [BC_W-1:0]   bcnt_q, bcnt_d;
   logic              inc_q, inc_d;
   logic              rd_q, rd_d;
   logic [7:0]        wr_data_q, wr_data_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              tx_load_q, tx_load_d;
   logic              overrun_q, overrun_d;
   logic              abort_q, abort_d;
   logic              fa_q;
   logic              addr_shift, addr_inc;

   spi_cmd_addr_ctr #(.ADDR_WIDTH(ADDR_WIDTH)) u_addr (
      .sys_clk (sys_clk),
      .reset_n (reset_n),
      .shift_i (addr_shift),
      .byte_i  (rx_byte),
      .inc_i   (addr_inc),
      .addr_o  (bus_addr)
   );

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      bcnt_d     = bcnt_q;
      inc_d      = inc_q;
      rd_d       = rd_q;
      wr_data_d  = wr_data_q;
      tx_byte_d  = tx_byte_q;
      tx_load_d  = 1'b0;
      overrun_d  = overrun_q;
      abort_d    = abort_q;
      addr_shift = 1'b0;
      addr_inc   = 1'b0;

      if (frame_active && !fa_q)
         overrun_d = 1'b0;

      case (state_q)
         ST_CMD: begin
            if (frame_active && rx_valid) begin
               op_d   = op_e'(rx_byte[CMD_OP_MSB:CMD_OP_LSB]);
               inc_d  = rx_byte[CMD_INC_BIT];
               bcnt_d = '0;
               if (op_e'(rx_byte[CMD_OP_MSB:CMD_OP_LSB]) == OP_CONTINUE) begin
                  rd_d    = rx_byte[CMD_DIR_BIT];
                  state_d = ST_LEN;
               end else begin
                  rd_d    = (op_e'(rx_byte[CMD_OP_MSB:CMD_OP_LSB]) == OP_READ);
                  state_d = ST_ADDR;
               end
            end
         end
         ST_ADDR: begin
            if (rx_valid) begin
               addr_shift = 1'b1;
               if (bcnt_q == BC_LAST)
                  state_d = (op_q == OP_SET_ADDR) ? ST_DONE : ST_LEN;
               else
                  bcnt_d = bcnt_q + BC_W'(1);
            end
         end
         ST_LEN: begin
            if (rx_valid) begin
               cnt_d   = (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
               state_d = rd_q ? ST_BUS : ST_WR_DATA;
            end
         end
         ST_WR_DATA: begin
            if (rx_valid) begin
               wr_data_d = rx_byte;
               state_d   = ST_BUS;
            end
         end
         ST_BUS: begin
            if (rx_valid)
               overrun_d = 1'b1;
            if (!frame_active)
               abort_d = 1'b1;
            if (bus_ack) begin
               addr_inc = inc_q;
               cnt_d    = cnt_q - 9'd1;
               abort_d  = 1'b0;
               // A frame that ended while the request was pending finishes
               // the bus cycle silently and returns straight to CMD.
               if (abort_q || !frame_active) begin
                  state_d = ST_CMD;
               end else begin
                  if (rd_q) begin
                     tx_byte_d = bus_rd_data;
                     tx_load_d = 1'b1;
                  end
                  if (cnt_q != 9'd1)
                     state_d = rd_q ? ST_RD_HOLD : ST_WR_DATA;
                  else
                     state_d = ST_DONE;
               end
            end
         end
         ST_RD_HOLD: begin
            if (rx_valid)
               state_d = ST_BUS;
         end
         ST_DONE: ;
         default: state_d = ST_CMD;
      endcase

      if (!frame_active && state_q != ST_BUS)
         state_d = ST_CMD;
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_CMD;
         op_q      <= OP_WRITE;
         cnt_q     <= '0;
         bcnt_q    <= '0;
         inc_q     <= 1'b0;
         rd_q      <= 1'b0;
         wr_data_q <= '0;
         tx_byte_q <= '0;
         tx_load_q <= 1'b0;
         overrun_q <= 1'b0;
         abort_q   <= 1'b0;
         fa_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         cnt_q     <= cnt_d;
         bcnt_q    <= bcnt_d;
         inc_q     <= inc_d;
         rd_q      <= rd_d;
         wr_data_q <= wr_data_d;
         tx_byte_q <= tx_byte_d;
         tx_load_q <= tx_load_d;
         overrun_q <= overrun_d;
         abort_q   <= abort_d;
         fa_q      <= frame_active;
      end
   end

   assign bus_req     = (state_q == ST_BUS);
   assign bus_we      = (state_q == ST_BUS) && !rd_q;
   assign bus_wr_data = wr_data_q;
   assign busy        = (state_q != ST_CMD);
   assign overrun     = overrun_q;
   assign tx_byte     = tx_byte_q;
   assign tx_load     = tx_load_q;

endmodule

// File: tb/tb_spi_cmd_bridge.sv
module tb_spi_cmd_bridge;

   localparam int AMASK = 32'h1FFFF;

   logic        sys_clk, reset_n, frame_active, rx_valid;
   logic [7:0]  rx_byte, tx_byte, bus_wr_data, bus_rd_data;
   logic        tx_load, bus_we, bus_req, bus_ack, busy, overrun;
   logic [16:0] bus_addr;

   spi_cmd_bridge #(.ADDR_WIDTH(17)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n), .frame_active(frame_active),
      .rx_byte(rx_byte), .rx_valid(rx_valid), .tx_byte(tx_byte), .tx_load(tx_load),
      .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_we(bus_we),
      .bus_req(bus_req), .bus_ack(bus_ack), .bus_rd_data(bus_rd_data),
      .busy(busy), .overrun(overrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   typedef struct packed {
      logic [16:0] a;
      logic        we;
      logic [7:0]  d;
   } tr_t;

   typedef struct {
      logic [63:0] bytes;
      int          nb;
      int          exp_n;
      logic [16:0] exp_last_a;
      logic [7:0]  exp_last_d;
      logic [16:0] exp_bus_addr;
   } vec_t;

   tr_t        tr_q[$], exp_tr[$];
   logic [7:0] tx_q[$], exp_tx[$];
   logic [7:0] fq[$];
   logic [7:0] resp_mem[int];
   logic [7:0] mdl_mem[int];
   int         ack_delay;
   int         n_vec, n_err;
   int         m_addr;

   function automatic logic [7:0] dflt(input int a);
      int v;
      v = (a * 37) ^ (a >> 8) ^ 32'h5A;
      return v[7:0];
   endfunction

   function automatic logic [7:0] resp_rd(input int a);
      return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
   endfunction

   function automatic logic [7:0] mdl_rd(input int a);
      return mdl_mem.exists(a) ? mdl_mem[a] : dflt(a);
   endfunction

   // Bus slave with programmable ack latency, plus tx_load monitor.
   initial begin : responder
      int   wcnt;
      tr_t  t;
      bus_ack = 1'b0;
      bus_rd_data = 8'h00;
      wcnt = 0;
      forever begin
         @(negedge sys_clk);
         if (tx_load) tx_q.push_back(tx_byte);
         if (bus_req && !bus_ack) begin
            if (wcnt >= ack_delay) begin
               t.a  = bus_addr;
               t.we = bus_we;
               t.d  = bus_we ? bus_wr_data : resp_rd(int'(bus_addr));
               if (bus_we) resp_mem[int'(bus_addr)] = bus_wr_data;
               tr_q.push_back(t);
               bus_rd_data = t.d;
               bus_ack = 1'b1;
               wcnt = 0;
            end else begin
               wcnt++;
            end
         end else begin
            bus_ack = 1'b0;
            bus_rd_data = 8'h00;
            if (!bus_req) wcnt = 0;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus_req && n < 100) begin
         @(negedge sys_clk);
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_idle: got bus_req stuck, expected ack");
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      wait_idle();
      rx_byte  = b;
      rx_valid = 1'b1;
      @(negedge sys_clk);
      rx_valid = 1'b0;
   endtask

   task automatic run_frame();
      frame_active = 1'b1;
      @(negedge sys_clk);
      foreach (fq[k]) send_byte(fq[k]);
      wait_idle();
      @(negedge sys_clk);
      frame_active = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   // Reference: what a well-behaved host frame should produce on the bus.
   task automatic model_frame();
      int i, n, avail, rd, inc;
      tr_t t;
      logic [7:0] cmd;
      if (fq.size() == 0) return;
      cmd = fq[0];
      inc = int'(cmd[5]);
      i = 1;
      if (cmd[7:6] != 2'b11) begin
         for (int k = 0; k < 3; k++) begin
            if (i >= fq.size()) return;
            m_addr = ((m_addr << 8) | int'(fq[i])) & AMASK;
            i++;
         end
         if (cmd[7:6] == 2'b10) return;
         rd = (cmd[7:6] == 2'b01) ? 1 : 0;
      end else begin
         rd = int'(cmd[4]);
      end
      if (i >= fq.size()) return;
      n = (fq[i] == 8'h00) ? 256 : int'(fq[i]);
      i++;
      avail = fq.size() - i;
      if (rd != 0) begin
         for (int k = 0; k < n && k < avail + 1; k++) begin
            t.a = m_addr[16:0]; t.we = 1'b0; t.d = mdl_rd(m_addr);
            exp_tr.push_back(t);
            exp_tx.push_back(t.d);
            m_addr = (m_addr + inc) & AMASK;
         end
      end else begin
         for (int k = 0; k < n && k < avail; k++) begin
            t.a = m_addr[16:0]; t.we = 1'b1; t.d = fq[i+k];
            exp_tr.push_back(t);
            mdl_mem[m_addr] = fq[i+k];
            m_addr = (m_addr + inc) & AMASK;
         end
      end
   endtask

   task automatic check_frame(input string tag);
      chk({tag, " n_trans"}, 32'(tr_q.size()), 32'(exp_tr.size()));
      for (int k = 0; k < exp_tr.size() && k < tr_q.size(); k++)
         chk($sformatf("%s trans%0d", tag, k), 32'(tr_q[k]), 32'(exp_tr[k]));
      chk({tag, " n_tx"}, 32'(tx_q.size()), 32'(exp_tx.size()));
      for (int k = 0; k < exp_tx.size() && k < tx_q.size(); k++)
         chk($sformatf("%s tx%0d", tag, k), 32'(tx_q[k]), 32'(exp_tx[k]));
      chk({tag, " bus_addr"}, 32'(bus_addr), 32'(m_addr));
      chk({tag, " overrun"}, 32'(overrun), 32'd0);
      tr_q.delete(); exp_tr.delete(); tx_q.delete(); exp_tx.delete();
   endtask

   vec_t vt[7];

   initial begin : main
      int nb, cnt;
      logic [7:0] cmd, len;
      tr_t t;
      n_vec = 0; n_err = 0; m_addr = 0; ack_delay = 0;
      reset_n = 1'b0; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;

      vt[0] = '{64'h2001800002AABB00, 7, 2, 17'h18001, 8'hBB, 17'h18002};
      vt[1] = '{64'h4000123403000000, 8, 3, 17'h01234, 8'h5C, 17'h01234};
      vt[2] = '{64'h8001FFFF00000000, 4, 0, 17'h00000, 8'h00, 17'h1FFFF};
      vt[3] = '{64'hF002000000000000, 3, 2, 17'h00000, dflt(0), 17'h00001};
      vt[4] = '{64'hE001770000000000, 3, 1, 17'h00001, 8'h77, 17'h00002};
      vt[5] = '{64'h8000000100000000, 4, 0, 17'h00000, 8'h00, 17'h00001};
      vt[6] = '{64'hDF01000000000000, 2, 1, 17'h00001, 8'h77, 17'h00001};

      repeat (2) @(negedge sys_clk);
      chk("rst bus_req", 32'(bus_req), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst tx_load", 32'(tx_load), 0);
      chk("rst overrun", 32'(overrun), 0);
      chk("rst bus_addr", 32'(bus_addr), 0);
      chk("rst tx_byte", 32'(tx_byte), 0);
      chk("rst bus_we", 32'(bus_we), 0);
      chk("rst bus_wr_data", 32'(bus_wr_data), 0);
      reset_n = 1'b1;
      @(negedge sys_clk);

      resp_mem[32'h1234] = 8'h5C;
      mdl_mem[32'h1234]  = 8'h5C;

      // Directed table
      for (int i = 0; i < 7; i++) begin
         fq.delete();
         for (int k = 0; k < vt[i].nb; k++) fq.push_back(vt[i].bytes[63-8*k -: 8]);
         ack_delay = i % 3;
         model_frame();
         run_frame();
         chk($sformatf("vec%0d n", i), 32'(tr_q.size()), 32'(vt[i].exp_n));
         if (vt[i].exp_n > 0 && tr_q.size() > 0) begin
            chk($sformatf("vec%0d last_a", i), 32'(tr_q[$].a), 32'(vt[i].exp_last_a));
            chk($sformatf("vec%0d last_d", i), 32'(tr_q[$].d), 32'(vt[i].exp_last_d));
         end
         chk($sformatf("vec%0d bus_addr", i), 32'(bus_addr), 32'(vt[i].exp_bus_addr));
         check_frame($sformatf("vec%0d", i));
      end

      // LEN 0 => 256 writes with increment
      fq.delete();
      fq.push_back(8'h20); fq.push_back(8'h00); fq.push_back(8'h01);
      fq.push_back(8'h00); fq.push_back(8'h00);
      for (int k = 0; k < 256; k++) fq.push_back(8'($urandom));
      ack_delay = 0;
      model_frame();
      run_frame();
      chk("len0 acks", 32'(tr_q.size()), 256);
      if (tr_q.size() == 256) chk("len0 last_a", 32'(tr_q[255].a), 32'h1FF);
      chk("len0 bus_addr", 32'(bus_addr), 32'h200);
      check_frame("len0");

      // Overrun: byte arriving during a long bus wait is dropped
      ack_delay = 10;
      frame_active = 1'b1;
      @(negedge sys_clk);
      send_byte(8'h20); send_byte(8'h00); send_byte(8'h00); send_byte(8'h10);
      send_byte(8'h02); send_byte(8'h11);
      chk("wr req", 32'(bus_req), 1);
      chk("wr we", 32'(bus_we), 1);
      chk("wr data", 32'(bus_wr_data), 32'h11);
      rx_byte = 8'h99; rx_valid = 1'b1;
      @(negedge sys_clk);
      rx_valid = 1'b0;
      chk("ovr set", 32'(overrun), 1);
      send_byte(8'h22);
      wait_idle();
      @(negedge sys_clk);
      chk("ovr sticky", 32'(overrun), 1);
      frame_active = 1'b0;
      repeat (2) @(negedge sys_clk);
      chk("ovr after frame", 32'(overrun), 1);
      frame_active = 1'b1;
      @(negedge sys_clk);
      chk("ovr cleared", 32'(overrun), 0);
      frame_active = 1'b0;
      @(negedge sys_clk);
      t = '{17'h10, 1'b1, 8'h11}; exp_tr.push_back(t);
      t = '{17'h11, 1'b1, 8'h22}; exp_tr.push_back(t);
      mdl_mem[32'h10] = 8'h11; mdl_mem[32'h11] = 8'h22;
      m_addr = 32'h12;
      check_frame("ovr");

      // Frame drops while a read is outstanding
      ack_delay = 6;
      frame_active = 1'b1;
      @(negedge sys_clk);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
      send_byte(8'h04);
      chk("rd req", 32'(bus_req), 1);
      chk("rd we", 32'(bus_we), 0);
      frame_active = 1'b0;
      cnt = 0;
      while (bus_req && cnt < 50) begin
         @(negedge sys_clk);
         cnt++;
      end
      chk("abort req_dropped", 32'(bus_req), 0);
      chk("abort busy", 32'(busy), 0);
      repeat (2) @(negedge sys_clk);
      t = '{17'h20, 1'b0, mdl_rd(32'h20)}; exp_tr.push_back(t);
      m_addr = 32'h20;
      check_frame("abort");

      // Randomised frames against the reference model
      for (int f = 0; f < 40; f++) begin
         fq.delete();
         cmd = 8'($urandom);
         fq.push_back(cmd);
         if (cmd[7:6] != 2'b11)
            for (int k = 0; k < 3; k++) fq.push_back(8'($urandom));
         if (cmd[7:6] == 2'b10) begin
            nb = $urandom_range(0, 2);
            for (int k = 0; k < nb; k++) fq.push_back(8'($urandom));
         end else begin
            len = 8'($urandom_range(1, 6));
            fq.push_back(len);
            nb = $urandom_range(0, int'(len) + 1);
            for (int k = 0; k < nb; k++) fq.push_back(8'($urandom));
         end
         ack_delay = $urandom_range(0, 3);
         model_frame();
         run_frame();
         check_frame($sformatf("rnd%0d", f));
      end

      // Async reset drops an outstanding request without a clock edge
      ack_delay = 8;
      frame_active = 1'b1;
      @(negedge sys_clk);
      send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
      send_byte(8'h01);
      chk("pre-rst req", 32'(bus_req), 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async rst req", 32'(bus_req), 0);
      chk("async rst busy", 32'(busy), 0);
      chk("async rst addr", 32'(bus_addr), 0);
      @(negedge sys_clk);
      reset_n = 1'b1;
      frame_active = 1'b0;
      repeat (2) @(negedge sys_clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_cmd_bridge.md
# spi_cmd_bridge

Parametrised successor to the single-transfer Pi command bridge. It decodes a framed byte stream from the SPI byte receiver into bus read/write bursts with configurable address width, byte-counted bursts, optional auto-increment, and address-retaining continuation commands. Read data is returned to the SPI transmitter. It sits between the SPI byte layer and the bus arbiter, in place of the Pi bridge.

## Interface
- `ADDR_WIDTH`, 17, bus address width.
  - Address bytes per command: `ADDR_BYTES = (ADDR_WIDTH+7)/8`, sent MSB first.
- `sys_clk` in 1: system clock; all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `frame_active` in 1: SPI chip-select active, synchronous to `sys_clk`; low aborts the frame.
- `rx_byte` in 8: received byte; valid only with `rx_valid`.
- `rx_valid` in 1: one-cycle strobe per received byte.
- `tx_byte` out 8: byte the SPI layer shifts out on the next transfer.
- `tx_load` out 1: one-cycle strobe when `tx_byte` is updated.
- `bus_addr` out ADDR_WIDTH: transaction address.
- `bus_wr_data` out 8: write data.
- `bus_we` out 1: 1 = write, 0 = read; valid while `bus_req`.
- `bus_req` out 1: request, held until acknowledged.
- `bus_ack` in 1: completes the request in the cycle it is sampled high.
- `bus_rd_data` in 8: read data, valid with `bus_ack` on reads.
- `busy` out 1: state ≠ CMD.
- `overrun` out 1: sticky; set when a byte is dropped; cleared by reset or by a new frame start (`frame_active` rising).

## Operation
- Command byte fields:
  - `[7:6]` op: 00 WRITE, 01 READ, 10 SET_ADDR, 11 CONTINUE.
  - `[5]` increment enable.
  - `[4]` CONTINUE direction: 1 = read.
  - `[3:0]` ignored.
- Byte sequences by op:
  - WRITE / READ: cmd, `ADDR_BYTES` address bytes, LEN, then data.
  - SET_ADDR: cmd, address bytes, then DONE. The address is kept for later commands.
  - CONTINUE: cmd, LEN, then data, using the retained address and counter.
- LEN 0 means 256 transfers; the count register is 9 bits.
- Address assembly:
  - Shifted in MSB first.
  - Excess high bits of the first byte are discarded.
- Increment:
  - After each acked transfer, `bus_addr` is incremented when inc = 1.
  - Wraps modulo 2^ADDR_WIDTH.
- States:
  - CMD: decode the command byte.
  - ADDR: collect address bytes (byte counter).
  - LEN: capture the count.
  - WR_DATA: wait for a data byte.
  - BUS: request outstanding.
  - RD_HOLD: read data presented; wait for the host's dummy byte.
  - DONE: ignore bytes until the frame ends.
- Transitions:
  - CMD→ADDR (ops 00/01/10), CMD→LEN (op 11).
  - ADDR→LEN, or ADDR→DONE for SET_ADDR.
  - LEN→WR_DATA for a write, LEN→BUS for a read.
  - WR_DATA→BUS.
  - BUS→WR_DATA or RD_HOLD while count > 0 after decrement; otherwise BUS→DONE.
  - RD_HOLD→BUS on `rx_valid`.
- On a read ack, `tx_byte` ← `bus_rd_data` and `tx_load` pulses.
- Op 11 with `[4]` = 0 is a write continuation. Reserved bits are never checked.
- Reset values:
  - All outputs 0. `bus_addr` 0, retained count 0.
  - State CMD.

## Timing
- Write path:
  - `rx_valid` on a data byte at cycle t → `bus_req`=1, `bus_we`=1, `bus_wr_data`=byte at t+1.
  - `bus_ack` at cycle a → `bus_req`=0 at a+1, with the address and count updated at a+1.
  - Zero-wait ack: minimum 2 cycles per transfer.
- Read path:
  - LEN byte at t → read request at t+1.
  - Ack at a → `tx_byte` valid and `tx_load` at a+1.
- `rx_valid` while in BUS (including the ack cycle) → byte dropped and `overrun` set at the next cycle.
- `frame_active` low:
  - No request outstanding → CMD at the next cycle.
  - In BUS → `bus_req` held until ack, then CMD. Read data is discarded: no `tx_load`.
  - A new command is not accepted until CMD is reached.
- `rx_valid` in DONE → ignored, no overrun.
- `reset_n` low mid-transfer → `bus_req` drops asynchronously. The bus side must tolerate an abandoned request.

## Structure
- `spi_cmd_pkg`:
  - Op enum (`OP_WRITE`, `OP_READ`, `OP_SET_ADDR`, `OP_CONTINUE`).
  - State enum.
  - Command-byte bit-position constants.
- One sub-module, `spi_cmd_addr_ctr`: ADDR_WIDTH-bit address register with byte-shift load, increment, and wrap.
- The FSM and count register live in the top module.

## Test plan
- ADDR_WIDTH=17: bytes 0x20, 0x01, 0x80, 0x00, 0x02, 0xAA, 0xBB → writes 0xAA@0x18000 and 0xBB@0x18001; DONE; `overrun` 0.
- READ with no increment: 0x40, 0x00, 0x12, 0x34, 0x03; memory@0x1234=0x5C; three dummy bytes → three reads of 0x1234, each giving `tx_byte`=0x5C with a `tx_load` pulse.
- SET_ADDR 0x1FFFF, then a new frame CONTINUE-read with inc (0xF0, LEN 0x02) → reads at 0x1FFFF, then 0x00000 (wrap).
- LEN 0x00 write with inc from 0x00100 → 256 acks, last address 0x001FF, final `bus_addr` 0x00200.
- Ack held off 10 cycles; extra `rx_valid` during BUS → byte dropped; `overrun`=1 until next frame start.
- `frame_active` low during an outstanding read → `bus_req` held until ack; no `tx_load`; state CMD the cycle after ack.
